ro_puf_evaluator: RTL and testbench

RO_PUF_EVALUATOR -- requirements
Module: ro_puf_evaluator

---
 rtl/ro_puf_evaluator.sv | 240 ++++++++++++++++++++++++
 tb/tb_ro_puf_evaluator.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_evaluator.sv
// Ring-oscillator PUF evaluator.
// Enables two rings, lets them settle for a warm-up period, then counts the
// rising edges of each ring over a fixed window of clk cycles. The response
// bit is 1 when ring A produced strictly more edges than ring B. Results are
// latched when the window closes and held until the next evaluation ends.
module ro_puf_evaluator #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int WARMUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_enable,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  // One down-counter times both the warm-up and the counting window, so it
  // is sized for the longer of the two. It only ever holds (length - 1).
  localparam int TMR_MAX = (WINDOW > WARMUP) ? WINDOW : WARMUP;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] WARMUP_LOAD = TMR_W'(WARMUP - 1);
  localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [TMR_W-1:0]   timer_reg;
  logic               timer_zero;

  // Strobes produced by the FSM output logic.
  logic               start_accept;  // start seen in IDLE
  logic               warmup_end;    // last warm-up cycle
  logic               count_en;      // edges are being counted this cycle
  logic               window_end;    // last counting cycle; results latch

  // Ring inputs gathered into a vector: bit 0 = ring A, bit 1 = ring B.
  logic [1:0]             ro_in;
  logic [1:0]             edge_det;
  logic [1:0][CNT_W-1:0]  cnt_next_vec;
  logic [1:0][CNT_W-1:0]  res_vec;

  logic                   response_reg;
  logic                   tie_reg;

  assign ro_in      = {ro_b, ro_a};
  assign timer_zero = (timer_reg == '0);

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------

  // State register; reset aborts any evaluation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: warm-up and window lengths are set by the shared timer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (timer_zero) begin
          state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (timer_zero) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode: rings run only in WARMUP and COUNT; start is only
  // honoured in IDLE, so a start while busy is simply dropped.
  always_comb begin
    ro_enable    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    start_accept = 1'b0;
    warmup_end   = 1'b0;
    count_en     = 1'b0;
    window_end   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy         = 1'b0;
        start_accept = start;
      end
      ST_WARMUP: begin
        ro_enable  = 1'b1;
        warmup_end = timer_zero;
      end
      ST_COUNT: begin
        ro_enable  = 1'b1;
        count_en   = 1'b1;
        window_end = timer_zero;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Phase timer
  // ------------------------------------------------------------------

  // Loaded with (length - 1) on entry to each timed phase and counted down;
  // the phase ends in the cycle where the timer reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if (start_accept) begin
      timer_reg <= WARMUP_LOAD;
    end else if (warmup_end) begin
      timer_reg <= WINDOW_LOAD;
    end else if (ro_enable && !timer_zero) begin
      timer_reg <= timer_reg - TMR_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Per-ring synchronizer, edge detector and saturating counter
  // ------------------------------------------------------------------

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_chan
    logic             sync1_reg;
    logic             sync2_reg;
    logic             sync3_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] res_reg;

    // Two flops bring the asynchronous ring output into the clk domain;
    // the third holds the previous synchronized value for edge detection.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        sync3_reg <= 1'b0;
      end else begin
        sync1_reg <= ro_in[gi];
        sync2_reg <= sync1_reg;
        sync3_reg <= sync2_reg;
      end
    end

    assign edge_det[gi] = sync2_reg & ~sync3_reg;

    // Count only inside the window, and stick at full scale instead of
    // wrapping so an over-fast ring still reads as "large".
    always_comb begin
      cnt_next = cnt_reg;
      if (count_en && edge_det[gi] && (cnt_reg != CNT_MAX)) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end

    // Working counter, cleared when a new evaluation is accepted.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (start_accept) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end

    // Result register captures the count including the final window cycle,
    // so it is already valid while done is high.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        res_reg <= '0;
      end else if (window_end) begin
        res_reg <= cnt_next;
      end
    end

    assign cnt_next_vec[gi] = cnt_next;
    assign res_vec[gi]      = res_reg;
  end

  // ------------------------------------------------------------------
  // Response comparison
  // ------------------------------------------------------------------

  // Compare the final counts as they are latched; equal counts give tie=1
  // with response=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      response_reg <= 1'b0;
      tie_reg      <= 1'b0;
    end else if (window_end) begin
      response_reg <= (cnt_next_vec[0] > cnt_next_vec[1]);
      tie_reg      <= (cnt_next_vec[0] == cnt_next_vec[1]);
    end
  end

  assign response = response_reg;
  assign tie      = tie_reg;
  assign count_a  = res_vec[0];
  assign count_b  = res_vec[1];

endmodule

// File: tb/tb_ro_puf_evaluator.sv
// Testbench for ro_puf_evaluator. Two instances share clock, reset and ring
// stimulus: a main one (CNT_W=16, WINDOW=80, WARMUP=8) and a narrow one
// (CNT_W=4, WINDOW=200, WARMUP=8) for saturation. A behavioural model derives
// every expected output from the recorded history of ring samples.
module tb_ro_puf_evaluator;

  localparam int M_W   = 8;
  localparam int M_WIN = 80;
  localparam int S_W   = 8;
  localparam int S_WIN = 200;
  localparam int HMAX  = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_m = 1'b0;
  logic        start_s = 1'b0;
  logic        ro_a = 1'b0;
  logic        ro_b = 1'b0;

  logic        m_en, m_busy, m_done, m_resp, m_tie;
  logic [15:0] m_ca, m_cb;
  logic        s_en, s_busy, s_done, s_resp, s_tie;
  logic [3:0]  s_ca, s_cb;

  int checks = 0;
  int failures = 0;

  ro_puf_evaluator #(.CNT_W(16), .WINDOW(M_WIN), .WARMUP(M_W)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .ro_a(ro_a), .ro_b(ro_b),
    .ro_enable(m_en), .busy(m_busy), .done(m_done), .response(m_resp),
    .tie(m_tie), .count_a(m_ca), .count_b(m_cb)
  );

  ro_puf_evaluator #(.CNT_W(4), .WINDOW(S_WIN), .WARMUP(S_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .ro_a(ro_a), .ro_b(ro_b),
    .ro_enable(s_en), .busy(s_busy), .done(s_done), .response(s_resp),
    .tie(s_tie), .count_a(s_ca), .count_b(s_cb)
  );

  always #5 clk = ~clk;

  // ---------------- ring stimulus ----------------
  int period_a = 0;
  int period_b = 0;
  bit b_copies_a = 1'b0;
  int phase = 0;

  function automatic bit wave(input int p, input int ph);
    return (p != 0) && ((ph % p) < (p / 2));
  endfunction

  initial begin
    bit va;
    forever begin
      @(negedge clk);
      phase = phase + 1;
      va = wave(period_a, phase);
      ro_a = va;
      ro_b = b_copies_a ? va : wave(period_b, phase);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist_x[n] is the ring value captured at clk edge n (0 while in reset).
  // An edge detected during cycle n is hist[n-1]=1 after hist[n-2]=0; a run
  // accepted at edge S counts cycles S+W .. S+W+WIN-1 and shows done in
  // cycle S+W+WIN.
  bit hist_a [HMAX];
  bit hist_b [HMAX];
  int e = 0;
  int mdl_w   [2] = '{M_W, S_W};
  int mdl_win [2] = '{M_WIN, S_WIN};
  int mdl_max [2] = '{65535, 15};
  int mdl_s   [2] = '{0, 0};
  bit mdl_act [2] = '{1'b0, 1'b0};
  int mdl_ca  [2] = '{0, 0};
  int mdl_cb  [2] = '{0, 0};
  bit mdl_resp[2] = '{1'b0, 1'b0};
  bit mdl_tie [2] = '{1'b0, 1'b0};

  initial begin
    bit st;
    int done_at;
    int ra;
    int rb;
    forever begin
      @(posedge clk);
      e = e + 1;
      if (e >= HMAX) begin
        $display("FAIL model_history: cycle %0d reached limit %0d", e, HMAX);
        $fatal(1, "history overflow");
      end
      hist_a[e] = rst_n ? ro_a : 1'b0;
      hist_b[e] = rst_n ? ro_b : 1'b0;
      if (!rst_n) begin
        hist_a[e-1] = 1'b0;
        hist_b[e-1] = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        st = (d == 0) ? start_m : start_s;
        if (!rst_n) begin
          mdl_act[d]  = 1'b0;
          mdl_ca[d]   = 0;
          mdl_cb[d]   = 0;
          mdl_resp[d] = 1'b0;
          mdl_tie[d]  = 1'b0;
        end else begin
          done_at = mdl_s[d] + mdl_w[d] + mdl_win[d];
          if (mdl_act[d] && (e - 1 == done_at)) begin
            mdl_act[d] = 1'b0;
          end else if (!mdl_act[d] && st) begin
            mdl_act[d] = 1'b1;
            mdl_s[d]   = e;
          end
          done_at = mdl_s[d] + mdl_w[d] + mdl_win[d];
          if (mdl_act[d] && (e == done_at)) begin
            ra = 0;
            rb = 0;
            for (int n = mdl_s[d] + mdl_w[d]; n < done_at; n++) begin
              if (hist_a[n-1] && !hist_a[n-2]) ra = ra + 1;
              if (hist_b[n-1] && !hist_b[n-2]) rb = rb + 1;
            end
            if (ra > mdl_max[d]) ra = mdl_max[d];
            if (rb > mdl_max[d]) rb = mdl_max[d];
            mdl_ca[d]   = ra;
            mdl_cb[d]   = rb;
            mdl_resp[d] = (ra > rb);
            mdl_tie[d]  = (ra == rb);
          end
        end
      end
    end
  end

  task automatic cmp_dut(input string tag, input int d, input int en, input int bz,
                         input int dn, input int rs, input int ti, input int ca,
                         input int cb);
    int done_at;
    done_at = mdl_s[d] + mdl_w[d] + mdl_win[d];
    chk({tag, "_busy"},      bz, int'(mdl_act[d]));
    chk({tag, "_ro_enable"}, en, int'(mdl_act[d] && (e < done_at)));
    chk({tag, "_done"},      dn, int'(mdl_act[d] && (e == done_at)));
    chk({tag, "_response"},  rs, int'(mdl_resp[d]));
    chk({tag, "_tie"},       ti, int'(mdl_tie[d]));
    chk({tag, "_count_a"},   ca, mdl_ca[d]);
    chk({tag, "_count_b"},   cb, mdl_cb[d]);
  endtask

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (e >= 1) begin
        cmp_dut("main", 0, int'(m_en), int'(m_busy), int'(m_done), int'(m_resp),
                int'(m_tie), int'(m_ca), int'(m_cb));
        cmp_dut("narrow", 1, int'(s_en), int'(s_busy), int'(s_done), int'(s_resp),
                int'(s_tie), int'(s_ca), int'(s_cb));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start(input int d);
    @(negedge clk);
    if (d == 0) start_m = 1'b1;
    else        start_s = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    start_s = 1'b0;
  endtask

  // Called right after pulse_start (cycle 1 after start was sampled).
  // Returns the cycle index at which done was seen and the number of cycles
  // ro_enable was high. Optional re-pulses of start and a ring-A stop point.
  task automatic run_wait(input int d, input int budget, input int rp1, input int rp2,
                          input int stop_a, output int lat, output int en_cycles);
    bit dn;
    bit en;
    lat = 1;
    en_cycles = 0;
    forever begin
      dn = (d == 0) ? m_done : s_done;
      en = (d == 0) ? m_en : s_en;
      if (en) en_cycles = en_cycles + 1;
      if (dn) break;
      if (lat >= budget) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL done_timeout: no done within %0d cycles (t=%0t)", budget, $time);
        break;
      end
      if (d == 0) start_m = (lat == rp1 || lat == rp2) ? 1'b1 : 1'b0;
      if (lat == stop_a) period_a = 0;
      @(negedge clk);
      lat = lat + 1;
    end
    start_m = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int en_cyc;
    int extra;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(m_busy), 0);
    chk("reset_ro_enable", int'(m_en), 0);
    chk("reset_done", int'(m_done), 0);
    chk("reset_count_a", int'(m_ca), 0);
    chk("reset_response", int'(m_resp), 0);
    rst_n = 1'b1;

    // Ring A period 8, ring B idle: A wins, ~10 edges in 80 cycles.
    period_a = 8; period_b = 0; b_copies_a = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start(0);
    run_wait(0, 300, 0, 0, 0, lat, en_cyc);
    chk("basic_latency", lat, 89);
    chk("basic_enable_cycles", en_cyc, 88);
    chk_range("basic_count_a", int'(m_ca), 9, 11);
    chk("basic_count_b", int'(m_cb), 0);
    chk("basic_response", int'(m_resp), 1);
    chk("basic_tie", int'(m_tie), 0);
    $display("run basic: latency=%0d count_a=%0d count_b=%0d response=%0d tie=%0d",
             lat, m_ca, m_cb, m_resp, m_tie);

    // Both rings from the same period-10 source: tie.
    period_a = 10; b_copies_a = 1'b1;
    pulse_start(0);
    run_wait(0, 300, 0, 0, 0, lat, en_cyc);
    chk_range("tie_count_a", int'(m_ca), 7, 9);
    chk("tie_equal", int'(m_cb), int'(m_ca));
    chk("tie_response", int'(m_resp), 0);
    chk("tie_flag", int'(m_tie), 1);
    $display("run tie: latency=%0d count_a=%0d count_b=%0d response=%0d tie=%0d",
             lat, m_ca, m_cb, m_resp, m_tie);

    // start re-pulsed during WARMUP and COUNT: ignored, not queued.
    b_copies_a = 1'b0; period_a = 4; period_b = 8;
    pulse_start(0);
    run_wait(0, 300, 5, 50, 0, lat, en_cyc);
    chk("repulse_latency", lat, 89);
    chk("repulse_response", int'(m_resp), 1);
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_done) extra = extra + 1;
    end
    chk("repulse_no_second_done", extra, 0);
    chk("repulse_idle_after", int'(m_busy), 0);
    $display("run repulse: latency=%0d count_a=%0d count_b=%0d extra_done=%0d",
             lat, m_ca, m_cb, extra);

    // One-cycle reset in the middle of COUNT.
    period_a = 6; period_b = 0;
    pulse_start(0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", int'(m_busy), 0);
    chk("abort_ro_enable", int'(m_en), 0);
    chk("abort_done", int'(m_done), 0);
    chk("abort_count_a", int'(m_ca), 0);
    chk("abort_count_b", int'(m_cb), 0);
    chk("abort_response", int'(m_resp), 0);
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_done) extra = extra + 1;
    end
    chk("abort_no_done", extra, 0);
    period_a = 0; period_b = 8;
    pulse_start(0);
    run_wait(0, 300, 0, 0, 0, lat, en_cyc);
    chk("abort_fresh_latency", lat, 89);
    chk_range("abort_fresh_count_b", int'(m_cb), 9, 11);
    chk("abort_fresh_response", int'(m_resp), 0);
    chk("abort_fresh_tie", int'(m_tie), 0);
    $display("run abort: extra_done=%0d fresh latency=%0d count_a=%0d count_b=%0d",
             extra, lat, m_ca, m_cb);

    // Ring A toggles in IDLE and early WARMUP only.
    period_a = 4; period_b = 0;
    repeat (10) @(negedge clk);
    pulse_start(0);
    run_wait(0, 300, 0, 0, 4, lat, en_cyc);
    chk("warmup_only_count_a", int'(m_ca), 0);
    chk("warmup_only_tie", int'(m_tie), 1);
    chk("warmup_only_response", int'(m_resp), 0);
    $display("run warmup_only: latency=%0d count_a=%0d count_b=%0d tie=%0d",
             lat, m_ca, m_cb, m_tie);

    // Narrow counter saturates at 15.
    period_a = 6; period_b = 0;
    pulse_start(1);
    run_wait(1, 500, 0, 0, 0, lat, en_cyc);
    chk("sat_latency", lat, 209);
    chk("sat_count_a", int'(s_ca), 15);
    chk("sat_count_b", int'(s_cb), 0);
    chk("sat_response", int'(s_resp), 1);
    $display("run saturate: latency=%0d count_a=%0d count_b=%0d response=%0d",
             lat, s_ca, s_cb, s_resp);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
